// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command driver: operation encoding,
// the queued command record, the driver FSM states and the reference arithmetic.
package alu_pkg;

  localparam int ALU_OP_W  = 4;
  localparam int ALU_RES_W = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  typedef struct packed {
    alu_op_e               op;
    logic [ALU_OP_W-1:0]   a;
    logic [ALU_OP_W-1:0]   b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } drv_state_e;

  // Result the ALU should return: zero-extended sum, or difference modulo 2^RES_W.
  function automatic logic [ALU_RES_W-1:0] alu_expect(input alu_op_e op,
                                                      input logic [ALU_OP_W-1:0] a,
                                                      input logic [ALU_OP_W-1:0] b);
    logic [ALU_RES_W-1:0] ax;
    logic [ALU_RES_W-1:0] bx;
    ax = ALU_RES_W'(a);
    bx = ALU_RES_W'(b);
    return (op == OP_SUB) ? (ax - bx) : (ax + bx);
  endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command stream, response stream and ALU operand bus of the command driver.
// master: the driver itself. slave: the host command source plus the ALU.
interface alu_cmd_driver_if #(
  parameter int OP_W  = alu_pkg::ALU_OP_W,
  parameter int RES_W = alu_pkg::ALU_RES_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [OP_W-1:0]  cmd_a;
  logic [OP_W-1:0]  cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_y;
  logic             rsp_op;

  logic             alu_en;
  logic             alu_op;
  logic [OP_W-1:0]  alu_a;
  logic [OP_W-1:0]  alu_b;
  logic [RES_W-1:0] alu_y;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_y,
    output cmd_ready, rsp_valid, rsp_y, rsp_op, alu_en, alu_op, alu_a, alu_b
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_y,
    input  cmd_ready, rsp_valid, rsp_y, rsp_op, alu_en, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers wrap naturally because DEPTH is a power of
// two; an explicit occupancy counter distinguishes full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  alu_cmd_t               push_data,
  input  logic                   pop,
  output alu_cmd_t               pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  alu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage, written on push.
  // NOTE: storage has no reset; entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator side of the ALU operand interface: queues add/sub commands, issues
// each as a single alu_en pulse, captures the ALU result and returns it on the
// response stream. One ALU operation is outstanding at a time.
// Optional macro ALU_CHECK_EN adds a sticky chk_err output that flags an ALU
// result differing from the expected sum/difference.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = ALU_OP_W,
  parameter int RES_W = ALU_RES_W
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_cmd_driver_if.master       bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_CHECK_EN
  ,
  output logic                   chk_err
`endif
);

  drv_state_e state;
  drv_state_e state_next;
  alu_cmd_t   push_cmd;
  alu_cmd_t   head;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       capture;
  logic       rsp_done;

  assign push_cmd      = '{op: alu_op_e'(bus.cmd_op), a: bus.cmd_a, b: bus.cmd_b};
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign busy          = !empty || (state != IDLE);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: ISSUE and CAPT are single cycles; RESP waits for the consumer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty) state_next = ISSUE;
      ISSUE:   state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = empty ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state actions: when to pop a command, capture the result, retire the response.
  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      CAPT:    capture = 1'b1;
      RESP: begin
        rsp_done = bus.rsp_ready;
        pop      = bus.rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // ALU drive: the pop edge loads operands and raises alu_en for one cycle;
  // operands hold their last value while alu_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.alu_en <= 1'b0;
      bus.alu_op <= 1'b0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
    end else begin
      bus.alu_en <= pop;
      if (pop) begin
        bus.alu_op <= head.op;
        bus.alu_a  <= OP_W'(head.a);
        bus.alu_b  <= OP_W'(head.b);
      end
    end
  end

  // Response register: loaded at the end of CAPT, held until the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_op    <= 1'b0;
    end else if (capture) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_y     <= RES_W'(bus.alu_y);
      bus.rsp_op    <= bus.alu_op;
    end else if (rsp_done) begin
      bus.rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_CHECK_EN
  // Sticky error flag: the ALU result disagrees with the operands still on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_err <= 1'b0;
    end else if (capture &&
                 (bus.alu_y != alu_expect(alu_op_e'(bus.alu_op), bus.alu_a, bus.alu_b))) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule
